// File: rtl/if_prefetch_queue.sv
// Instruction-fetch prefetch queue: issues sequential word fetches, buffers
// {instr, pc+4} in a small FIFO and discards the in-flight word on redirect.
module if_prefetch_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   start_pc,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          out_valid,
  output logic [31:0]   out_instr,
  output logic [31:0]   out_pcplus4,
  input  logic          out_ready,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {FETCH, DROP} state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     target_pc_q, target_pc_d;
  logic [31:0]     addr_q, addr_d;
  logic            req_q, req_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d, pc4_q, pc4_d;
  logic [31:0]     instr_mem_q [DEPTH];
  logic [31:0]     instr_mem_d [DEPTH];
  logic [31:0]     pc4_mem_q [DEPTH];
  logic [31:0]     pc4_mem_d [DEPTH];
  logic            push, pop, flush;
  logic [31:0]     redirect_word;
  logic            unused_low_bits;

  assign redirect_word   = {redirect_pc[31:2], 2'b00};
  assign unused_low_bits = ^redirect_pc[1:0];

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    target_pc_d = target_pc_q;
    push        = 1'b0;
    pop         = 1'b0;
    flush       = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          flush = 1'b1;
          if (req_q && !imem_ack) begin
            // The old fetch must still complete on the bus; its data is dropped.
            target_pc_d = redirect_word;
            state_d     = DROP;
          end else begin
            fetch_pc_d = redirect_word;
          end
        end else begin
          pop = valid_q && out_ready;
          if (req_q && imem_ack) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
          end
        end
      end
      DROP: begin
        flush = redirect;
        if (redirect) target_pc_d = redirect_word;
        if (imem_ack) begin
          fetch_pc_d = redirect ? redirect_word : target_pc_q;
          state_d    = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    instr_mem_d = instr_mem_q;
    pc4_mem_d   = pc4_mem_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_mem_d[wr_ptr_q] = imem_rdata;
        pc4_mem_d[wr_ptr_q]   = fetch_pc_q + 32'd4;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CW'(push) - CW'(pop);
    end
    // Outputs are registered, so the head is looked up from next-state contents.
    valid_d = (count_d != '0);
    instr_d = valid_d ? instr_mem_d[rd_ptr_d] : 32'd0;
    pc4_d   = valid_d ? pc4_mem_d[rd_ptr_d] : 32'd0;
  end

  always_comb begin
    req_d  = 1'b0;
    addr_d = fetch_pc_d;
    if (state_d == DROP) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else if (state_q == DROP) begin
      req_d  = 1'b0;
    end else if (req_q && !imem_ack && !redirect) begin
      req_d  = 1'b1;
      addr_d = addr_q;
    end else begin
      req_d  = (count_d < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      fetch_pc_q  <= start_pc;
      target_pc_q <= start_pc;
      addr_q      <= start_pc;
      req_q       <= 1'b0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      instr_q     <= 32'd0;
      pc4_q       <= 32'd0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      target_pc_q <= target_pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      pc4_q       <= pc4_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_mem_q <= instr_mem_d;
    pc4_mem_q   <= pc4_mem_d;
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign out_valid   = valid_q;
  assign out_instr   = instr_q;
  assign out_pcplus4 = pc4_q;
  assign count       = count_q;
endmodule
